// File: rtl/mp_add_pkg.sv
// Shared constants and FSM state encoding for the multi-precision add sequencer.
package mp_add_pkg;

  localparam int LIMB_W_DEF  = 64;
  localparam int LIMBS_DEF   = 4;
  localparam int ADD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mp_add_sequencer.sv
// Splits wide operands into limbs, feeds them one at a time to an external
// registered adder stage with chained carry, and presents the assembled sum.
module mp_add_sequencer
  import mp_add_pkg::*;
#(
  parameter int LIMB_W  = LIMB_W_DEF,
  parameter int LIMBS   = LIMBS_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LIMB_W*LIMBS-1:0]   in_a,
  input  logic [LIMB_W*LIMBS-1:0]   in_b,
  input  logic                      in_cin,
  output logic [LIMB_W-1:0]         add_a,
  output logic [LIMB_W-1:0]         add_b,
  output logic                      add_cin,
  input  logic [LIMB_W-1:0]         add_sum,
  input  logic                      add_cout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LIMB_W*LIMBS-1:0]   out_sum,
  output logic                      out_cout
);

  localparam int W      = LIMB_W * LIMBS;
  localparam int IDX_W  = (LIMBS > 1) ? $clog2(LIMBS) : 1;
  localparam int WCNT_W = $clog2(ADD_LAT + 1);

  state_t              state_r;
  logic [W-1:0]        a_r;
  logic [W-1:0]        b_r;
  logic                carry_r;
  logic [IDX_W-1:0]    idx_r;
  logic [WCNT_W-1:0]   wcnt_r;
  logic [W-1:0]        sum_r;
  logic                cout_r;
  logic                in_ready_r;
  logic                out_valid_r;
  logic [LIMB_W-1:0]   add_a_r;
  logic [LIMB_W-1:0]   add_b_r;
  logic                add_cin_r;
  logic [IDX_W:0]      nxt_idx_s;
  logic                last_limb_s;
  logic                lat_done_s;

  // Shift-based select so an index past the top limb yields zero instead of X.
  function automatic logic [LIMB_W-1:0] limb_of(input logic [W-1:0] v, input logic [IDX_W:0] k);
    logic [W-1:0] sh;
    sh = v >> (int'(k) * LIMB_W);
    return sh[LIMB_W-1:0];
  endfunction

  assign nxt_idx_s   = {1'b0, idx_r} + {{IDX_W{1'b0}}, 1'b1};
  assign last_limb_s = (idx_r == IDX_W'(LIMBS - 1));
  assign lat_done_s  = (wcnt_r == WCNT_W'(ADD_LAT));

  // Sequencer FSM; adder-facing limb outputs are reloaded whenever idx moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      a_r         <= '0;
      b_r         <= '0;
      carry_r     <= 1'b0;
      idx_r       <= '0;
      wcnt_r      <= '0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      add_a_r     <= '0;
      add_b_r     <= '0;
      add_cin_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r        <= in_a;
            b_r        <= in_b;
            carry_r    <= in_cin;
            idx_r      <= '0;
            sum_r      <= '0;
            add_a_r    <= in_a[LIMB_W-1:0];
            add_b_r    <= in_b[LIMB_W-1:0];
            add_cin_r  <= in_cin;
            in_ready_r <= 1'b0;
            state_r    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          wcnt_r  <= WCNT_W'(1);
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_done_s) begin
            sum_r[int'(idx_r)*LIMB_W +: LIMB_W] <= add_sum;
            carry_r <= add_cout;
            if (last_limb_s) begin
              cout_r      <= add_cout;
              out_valid_r <= 1'b1;
              state_r     <= ST_DONE;
            end else begin
              idx_r     <= nxt_idx_s[IDX_W-1:0];
              add_a_r   <= limb_of(a_r, nxt_idx_s);
              add_b_r   <= limb_of(b_r, nxt_idx_s);
              add_cin_r <= add_cout;
              state_r   <= ST_ISSUE;
            end
          end else begin
            wcnt_r <= wcnt_r + WCNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = sum_r;
  assign out_cout  = cout_r;
  assign add_a     = add_a_r;
  assign add_b     = add_b_r;
  assign add_cin   = add_cin_r;

endmodule

// File: tb/tb_mp_add_sequencer.sv
// Randomized bench for mp_add_sequencer against a wide-integer reference sum,
// with the adder stage modelled as an ADD_LAT-deep registered limb adder.
module tb_mp_add_sequencer;
  import mp_add_pkg::*;

  localparam int LW  = LIMB_W_DEF;
  localparam int NL  = LIMBS_DEF;
  localparam int AL  = ADD_LAT_DEF;
  localparam int W   = LW * NL;
  localparam int LAT = 1 + NL * (AL + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main instance (default configuration)
  logic          in_valid = 1'b0, in_ready, in_cin = 1'b0;
  logic [W-1:0]  in_a = '0, in_b = '0, out_sum;
  logic [LW-1:0] add_a, add_b, add_sum;
  logic          add_cin, add_cout, out_valid, out_ready = 1'b0, out_cout;

  // single-limb, single-cycle-adder instance
  logic          s_in_valid = 1'b0, s_in_ready, s_in_cin = 1'b0;
  logic [LW-1:0] s_in_a = '0, s_in_b = '0, s_out_sum;
  logic [LW-1:0] s_add_a, s_add_b, s_add_sum;
  logic          s_add_cin, s_add_cout, s_out_valid, s_out_ready = 1'b0, s_out_cout;

  int n_checks = 0;
  int n_fail   = 0;

  mp_add_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  mp_add_sequencer #(.LIMB_W(LW), .LIMBS(1), .ADD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin),
    .add_a(s_add_a), .add_b(s_add_b), .add_cin(s_add_cin),
    .add_sum(s_add_sum), .add_cout(s_add_cout),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum), .out_cout(s_out_cout)
  );

  // adder stage models: registered LW-bit add, AL and 1 cycles deep
  logic [LW:0] pipe [AL];
  logic [LW:0] pipe1;
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + {{LW{1'b0}}, add_cin};
    for (int i = 1; i < AL; i++) pipe[i] <= pipe[i-1];
    pipe1 <= {1'b0, s_add_a} + {1'b0, s_add_b} + {{LW{1'b0}}, s_add_cin};
  end
  assign add_sum    = pipe[AL-1][LW-1:0];
  assign add_cout   = pipe[AL-1][LW];
  assign s_add_sum  = pipe1[LW-1:0];
  assign s_add_cout = pipe1[LW];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [LW-1:0] limb(input logic [W-1:0] v, input int k);
    return v[k*LW +: LW];
  endfunction

  // carry into limb k = top bit of the sum of the operands truncated to k limbs
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic cin, input int k);
    logic [W:0] m, s;
    m = ({{W{1'b0}}, 1'b1} << (k * LW)) - {{W{1'b0}}, 1'b1};
    s = ({1'b0, a} & m) + ({1'b0, b} & m) + {{W{1'b0}}, cin};
    return s[k*LW];
  endfunction

  function automatic logic [W-1:0] rnd_wide();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input int hold, input bit overlap,
                        input logic [W-1:0] na, input logic [W-1:0] nb, input string tag);
    logic [W:0]   want;
    logic [W-1:0] held;
    int n, lim, k;
    want = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    lim = 0;
    while (!in_ready && lim < 100) begin
      @(negedge clk);
      lim++;
    end
    check({tag, " in_ready"}, in_ready, 1);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin
      if ((n - 1) % (AL + 1) == 0 && (n - 1) / (AL + 1) < NL) begin
        k = (n - 1) / (AL + 1);
        check($sformatf("%s add_a limb%0d", tag, k), add_a, limb(a, k));
        check($sformatf("%s add_cin limb%0d", tag, k), add_cin, carry_into(a, b, cin, k));
      end
      if (n == 2) begin
        check({tag, " busy in_ready"}, in_ready, 0);
        if (overlap) begin
          in_a = na; in_b = nb; in_cin = 1'b0; in_valid = 1'b1;
        end
      end
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, LAT);
    check({tag, " sum"}, out_sum, want[W-1:0]);
    check({tag, " cout"}, out_cout, want[W]);
    held = out_sum;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold valid"}, out_valid, 1);
      check({tag, " hold sum"}, out_sum, held);
      check({tag, " hold in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " post valid"}, out_valid, 0);
    check({tag, " post in_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [W-1:0] ones, a2, b2, ra, rb;
    int n;
    bit seen;
    ones = '1;

    repeat (3) @(negedge clk);
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_sum", out_sum, 0);
    check("rst out_cout", out_cout, 0);
    check("rst add_a", add_a, 0);
    check("rst add_b", add_b, 0);
    check("rst add_cin", add_cin, 0);
    check("rst1 in_ready", s_in_ready, 1);
    check("rst1 out_valid", s_out_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(ones, W'(1), 1'b0, 0, 1'b0, '0, '0, "ripple");
    run_op(W'(5), W'(7), 1'b1, 0, 1'b0, '0, '0, "simple");

    // backpressure with a competing request that must wait for the handshake
    a2 = rnd_wide(); b2 = rnd_wide();
    run_op(rnd_wide(), rnd_wide(), 1'b1, 5, 1'b1, a2, b2, "bp");
    run_op(a2, b2, 1'b0, 0, 1'b0, '0, '0, "after_bp");

    // reset during limb 2 wait
    in_a = rnd_wide(); in_b = rnd_wide(); in_cin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (n = 1; n < 2 * (AL + 1) + 2; n++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst in_ready", in_ready, 1);
    check("midrst out_valid", out_valid, 0);
    check("midrst out_sum", out_sum, 0);
    check("midrst add_a", add_a, 0);
    check("midrst add_cin", add_cin, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst no out_valid", seen, 0);
    run_op(W'(1) << 128, W'(1) << 128, 1'b0, 0, 1'b0, '0, '0, "pow128");

    run_op(ones, ones, 1'b1, 1, 1'b0, '0, '0, "allones");
    for (int t = 0; t < 6; t++) begin
      ra = rnd_wide(); rb = rnd_wide();
      run_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, '0, '0,
             $sformatf("rand%0d", t));
    end

    // single-limb configuration
    s_in_a = '1; s_in_b = '1; s_in_cin = 1'b1; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    n = 1;
    while (!s_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("cfg1 latency", n, 1 + 1 * (1 + 1));
    check("cfg1 sum", s_out_sum, {LW{1'b1}});
    check("cfg1 cout", s_out_cout, 1);
    s_out_ready = 1'b1;
    @(negedge clk);
    s_out_ready = 1'b0;
    check("cfg1 post valid", s_out_valid, 0);
    check("cfg1 post in_ready", s_in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
